// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Brief    : Shared constants for the key debouncer: channel FSM state
//            encoding, default timing values and counter sizing helpers.
// Revision : 1.0 - initial release
// ============================================================================
package key_pkg;

    localparam int c_debounce_cycles_dflt = 20000;
    localparam int c_long_cycles_dflt     = 1000000;

    // Bit 1 of the encoding is set exactly in the states where the key is
    // considered pressed, so the debounced level decodes directly from it.
    localparam logic [1:0] c_st_released    = 2'd0;
    localparam logic [1:0] c_st_press_chk   = 2'd1;
    localparam logic [1:0] c_st_pressed     = 2'd2;
    localparam logic [1:0] c_st_release_chk = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter serves both debounce and long-press timing.
    function automatic int cnt_width(input int deb_cycles, input int long_cycles);
        int m;
        m = max_int(deb_cycles, long_cycles);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_ch
// Brief    : One key channel: 2-flop synchronizer, 4-state debounce FSM and
//            a shared saturating counter. Long-press detection is built only
//            when KEY_DEBOUNCE_LONGPRESS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_dflt,
    parameter int LONG_CYCLES     = c_long_cycles_dflt
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int                 c_cnt_w    = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;

    logic [1:0]         r_sync;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               r_press;
    logic               r_release;
    logic               w_press_nxt;
    logic               w_release_nxt;
    logic               w_in;

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    localparam logic [c_cnt_w-1:0] c_long_last = c_cnt_w'(LONG_CYCLES - 1);
    logic r_long;
    logic r_long_done;
    logic w_long_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], key_raw};
        end
    end

    assign w_in      = r_sync[1];
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        w_long_nxt    = 1'b0;
`endif
        case (r_state)
            c_st_released: begin
                if (w_in) begin
                    w_state_nxt = c_st_press_chk;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_press_chk: begin
                if (!w_in) begin
                    w_state_nxt = c_st_released;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = c_st_pressed;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            c_st_pressed: begin
                if (!w_in) begin
                    w_state_nxt = c_st_release_chk;
                    w_cnt_nxt   = '0;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
                end else if (!r_long_done) begin
                    // Counter parks on the terminal value once the pulse fires.
                    if (r_cnt == c_long_last) begin
                        w_long_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt  = w_cnt_inc;
                    end
`endif
                end
            end
            c_st_release_chk: begin
                if (w_in) begin
                    w_state_nxt   = c_st_pressed;
                    w_cnt_nxt     = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt   = c_st_released;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = c_st_released;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_released;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    // One long pulse per press; re-armed only by an accepted release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_long      <= 1'b0;
            r_long_done <= 1'b0;
        end else begin
            r_long <= w_long_nxt;
            if (w_release_nxt) begin
                r_long_done <= 1'b0;
            end else if (w_long_nxt) begin
                r_long_done <= 1'b1;
            end
        end
    end

    assign key_long = r_long;
`else
    assign key_long = 1'b0;
`endif

    assign key_level   = r_state[1];
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : NUM_KEYS independent debounced key channels with press, release
//            and long-press pulses. Long-press counting is enabled by the
//            macro KEY_DEBOUNCE_LONGPRESS_EN; otherwise key_long stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_dflt,
    parameter int LONG_CYCLES     = c_long_cycles_dflt
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LONG_CYCLES     (LONG_CYCLES)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .key_raw     (key_raw[gi]),
                .key_level   (key_level[gi]),
                .key_press   (key_press[gi]),
                .key_release (key_release[gi]),
                .key_long    (key_long[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce
// Brief    : Directed and random stimulus for key_debounce, checked every cycle
//            against a sliding-window model of the debounce rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    localparam int          c_keys      = 8;
    localparam int          c_deb       = 4;
    localparam int          c_long      = 16;
    localparam logic [63:0] c_deb_mask  = (64'd1 << (c_deb + 1)) - 64'd1;
    localparam logic [63:0] c_long_mask = (64'd1 << (c_long + 1)) - 64'd1;

    logic              clk = 1'b0;
    logic              rst;
    logic [c_keys-1:0] key_raw;
    logic [c_keys-1:0] key_level;
    logic [c_keys-1:0] key_press;
    logic [c_keys-1:0] key_release;
    logic [c_keys-1:0] key_long;

    always #5 clk = ~clk;

    key_debounce #(
        .NUM_KEYS        (c_keys),
        .DEBOUNCE_CYCLES (c_deb),
        .LONG_CYCLES     (c_long)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_press;
    int n_release;
    int n_long;

    // Reference: synchronizer delay plus a per-key history of sampled values.
    logic [c_keys-1:0] m_d1, m_d2;
    logic [c_keys-1:0] m_level, m_press, m_release, m_long, m_fired;
    logic [63:0]       m_hist [c_keys];
    int                m_since [c_keys];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0;
        m_release = '0; m_long = '0; m_fired = '0;
        for (int k = 0; k < c_keys; k++) begin
            m_hist[k]  = '0;
            m_since[k] = 0;
        end
    endtask

    // A level change is accepted once the last DEB+1 samples all disagree with
    // the current level; a long press needs LONG+1 consecutive held samples,
    // at least LONG edges after acceptance, once per press.
    task automatic model_edge();
        logic [c_keys-1:0] samp;
        samp = m_d2;
        m_d2 = m_d1;
        m_d1 = key_raw;
        m_press = '0; m_release = '0; m_long = '0;
        for (int k = 0; k < c_keys; k++) begin
            m_hist[k] = {m_hist[k][62:0], samp[k]};
            if (!m_level[k] && ((m_hist[k] & c_deb_mask) == c_deb_mask)) begin
                m_level[k] = 1'b1; m_press[k] = 1'b1;
                m_since[k] = 0;    m_fired[k] = 1'b0;
            end else if (m_level[k] && ((m_hist[k] & c_deb_mask) == 64'd0)) begin
                m_level[k] = 1'b0; m_release[k] = 1'b1;
            end else if (m_level[k]) begin
                m_since[k]++;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
                if (!m_fired[k] && m_since[k] >= c_long &&
                    ((m_hist[k] & c_long_mask) == c_long_mask)) begin
                    m_long[k]  = 1'b1;
                    m_fired[k] = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic step(input logic [c_keys-1:0] raw);
        key_raw = raw;
        @(posedge clk);
        if (rst) model_clear();
        else     model_edge();
        @(negedge clk);
        check("level",   key_level,   m_level);
        check("press",   key_press,   m_press);
        check("release", key_release, m_release);
        check("long",    key_long,    m_long);
        n_press   += $countones(key_press);
        n_release += $countones(key_release);
        n_long    += $countones(key_long);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int                lat;
        int                lat2;
        int                next_bit;
        int                den;
        logic [c_keys-1:0] act;
        logic [c_keys-1:0] pv;
        logic [c_keys-1:0] rv;
        logic [c_keys-1:0] r;

        rst = 1'b1; key_raw = '0;
        model_clear();
        n_press = 0; n_release = 0; n_long = 0;
        repeat (3) @(negedge clk);
        check("rst_level",   key_level,   8'h00);
        check("rst_press",   key_press,   8'h00);
        check("rst_release", key_release, 8'h00);
        check("rst_long",    key_long,    8'h00);
        rst = 1'b0;
        repeat (5) step('0);

        // Clean press on key 0: pulse six edges after the sampling edge.
        n_press = 0; lat = -1;
        for (int i = 0; i < 20; i++) begin
            step(8'h01);
            if (lat < 0 && key_press[0]) lat = i;
        end
        check("press_latency", lat, 6);
        check("press_count", n_press, 1);
        check("level_held", key_level, 8'h01);
        repeat (12) step('0);

        // Three-cycle glitch on key 3 must stay invisible.
        act = '0;
        for (int i = 0; i < 15; i++) begin
            step((i < 3) ? 8'h08 : 8'h00);
            act |= key_level | key_press | key_release;
        end
        check("glitch_quiet", act, 8'h00);

        // Simultaneous presses, then mixed press/release in one cycle.
        pv = '0; lat = 0;
        for (int i = 0; i < 12; i++) begin
            step(8'hF0);
            if (key_press != 0) begin
                lat++;
                if (pv == 0) pv = key_press;
            end
        end
        check("multi_press", pv, 8'hF0);
        check("multi_press_cycles", lat, 1);
        rv = '0; pv = '0;
        for (int i = 0; i < 12; i++) begin
            step(8'b1001_0011);
            if (rv == 0 && key_release != 0) begin
                rv = key_release;
                pv = key_press;
            end
        end
        check("mixed_release", rv, 8'h60);
        check("mixed_press", pv, 8'h03);
        repeat (30) step('0);

        // Reset two cycles into the press check, key held through deassertion.
        repeat (4) step(8'h01);
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_mid_chk_level", key_level, 8'h00);
        repeat (3) step(8'h01);
        rst = 1'b0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            step(8'h01);
            if (lat < 0 && key_press[0]) lat = i;
        end
        check("rst_held_latency", lat, 6);

        // Reset while pressed clears the level at once and emits nothing later.
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_async_level", key_level, 8'h00);
        repeat (2) step(8'h00);
        rst = 1'b0;
        act = '0;
        for (int i = 0; i < 12; i++) begin
            step('0);
            act |= key_level | key_press | key_release | key_long;
        end
        check("rst_no_pulse", act, 8'h00);

        // Long hold on key 7.
        n_long = 0; lat = -1; lat2 = -1;
        for (int i = 0; i < 40; i++) begin
            step(8'h80);
            if (lat < 0 && key_press[7]) lat = i;
            if (lat2 < 0 && key_long[7]) lat2 = i;
        end
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        check("long_count", n_long, 1);
        check("long_gap", lat2 - lat, 16);
`else
        check("long_count", n_long, 0);
`endif
        repeat (12) step('0);

        // Walking one-hot press, 500 ns per key.
        n_press = 0; n_release = 0; next_bit = 0;
        for (int k = 0; k < c_keys; k++) begin
            for (int i = 0; i < 50; i++) begin
                step(c_keys'(1) << k);
                if (key_press != 0) begin
                    check("walk_order", key_press, 32'd1 << next_bit);
                    next_bit++;
                end
            end
        end
        for (int i = 0; i < 50; i++) step('0);
        check("walk_presses", n_press, 8);
        check("walk_releases", n_release, 8);

        // Random bounce/hold mix with one asynchronous reset in the middle.
        r = '0; den = 40;
        for (int c = 0; c < 1600; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       den = 3;
                    1:       den = 8;
                    default: den = 40;
                endcase
            end
            for (int k = 0; k < c_keys; k++)
                if ($urandom_range(0, den - 1) == 0) r[k] = ~r[k];
            if (c == 777) rst = 1'b1;
            if (c == 780) rst = 1'b0;
            step(r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 8: number of independent key channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 20000: stable cycles required to accept a level change; legal range 2..2^20.
REQ-003 The block SHALL have parameter LONG_CYCLES, default 1000000: held cycles, counted after the press is accepted, before a long-press event.
REQ-004 The block SHALL have port clk, input, 1: system clock.
REQ-005 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 The block SHALL have port key_raw, input, NUM_KEYS: asynchronous raw keys, 1 = pressed.
REQ-007 The block SHALL have port key_level, output, NUM_KEYS: debounced key state, 1 = pressed.
REQ-008 The block SHALL have port key_press, output, NUM_KEYS: one-cycle pulse on an accepted press.
REQ-009 The block SHALL have port key_release, output, NUM_KEYS: one-cycle pulse on an accepted release.
REQ-010 The block SHALL have port key_long, output, NUM_KEYS: one-cycle long-press pulse; this port SHALL always exist.

Function
REQ-011 Each key_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL run an independent FSM with the states RELEASED, PRESS_CHK, PRESSED and RELEASE_CHK.
REQ-013 In RELEASED, a synchronized 1 SHALL move the FSM to PRESS_CHK and clear the counter.
REQ-014 In PRESS_CHK, the counter SHALL increment each cycle while the synchronized input is 1.
REQ-015 In PRESS_CHK, a synchronized 0 SHALL return the FSM to RELEASED and clear the counter, with no output change.
REQ-016 When the PRESS_CHK counter reaches DEBOUNCE_CYCLES-1, the FSM SHALL enter PRESSED, set key_level to 1, and pulse key_press for exactly 1 cycle.
REQ-017 RELEASE_CHK SHALL mirror PRESS_CHK with the input polarity inverted; on acceptance it SHALL clear key_level and pulse key_release.
REQ-018 Latency SHALL be exactly DEBOUNCE_CYCLES+2 rising edges from the first edge that samples the new raw level to the edge asserting key_level or the pulse, given a stable input.
REQ-019 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output activity.
REQ-020 Counter width SHALL be $clog2 of max(DEBOUNCE_CYCLES, LONG_CYCLES), and the counter SHALL saturate rather than wrap.
REQ-021 Channels SHALL be fully independent; simultaneous events on any set of keys SHALL produce simultaneous pulses on the matching bits.
REQ-022 key_press, key_release and key_long SHALL never be asserted on the same bit in the same cycle.

Reset
REQ-023 Asserting rst SHALL immediately force all FSMs to RELEASED and clear counters, synchronizers, key_level, key_press, key_release and key_long.
REQ-024 Reset asserted mid-debounce or mid-press SHALL discard that event, with no pulse on deassertion.
REQ-025 A key held through reset deassertion SHALL be treated as a new press: key_press SHALL follow after DEBOUNCE_CYCLES+2 cycles.

Configuration
REQ-026 With macro KEY_DEBOUNCE_LONGPRESS_EN defined, in PRESSED the counter SHALL count held cycles, and key_long SHALL pulse once when the count reaches LONG_CYCLES-1.
REQ-027 With KEY_DEBOUNCE_LONGPRESS_EN defined, after a key_long pulse no further key_long SHALL occur until the key is released and pressed again.
REQ-028 With KEY_DEBOUNCE_LONGPRESS_EN undefined, key_long SHALL be tied to 0 and no long-press counting logic SHALL be synthesized.

Structure
REQ-029 A shared package key_pkg SHALL hold the FSM state encoding (2-bit: RELEASED=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3) and the default DEBOUNCE_CYCLES and LONG_CYCLES constants.
REQ-030 A sub-module key_debounce_ch SHALL implement one channel (synchronizer, FSM and counter), and the top SHALL instantiate it NUM_KEYS times in a generate loop.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-031 A clean press on key_raw=8'b0000_0001 held 20 cycles SHALL produce key_press[0] for 1 cycle 6 edges after the sample edge, and key_level[0]=1 from that edge on.
REQ-032 A 3-cycle pulse on key_raw[3] SHALL leave key_level, key_press and key_release at 0 throughout.
REQ-033 key_raw=8'b1111_0000 applied in one cycle SHALL pulse key_press=8'hF0 in a single cycle; a later change to 8'b1001_0011 SHALL pulse key_release=8'h60 and key_press=8'h03 in the same cycle.
REQ-034 Asserting rst 2 cycles into a PRESS_CHK, with the key still held at deassertion, SHALL keep outputs at 0 during reset and pulse key_press 6 edges after deassertion.
REQ-035 With KEY_DEBOUNCE_LONGPRESS_EN, holding key_raw[7] for 40 cycles SHALL pulse key_long[7] exactly once, 16 cycles after key_press[7]; without the macro, key_long SHALL remain 0.
REQ-036 Walking a one-hot press (500 ns each) across all 8 keys SHALL produce exactly 8 key_press and 8 key_release pulses, in bit order.
